// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: shared definitions for the cache AXI read-channel arbiter.
// Holds the FSM state encoding, requester IDs and the default burst length.
package cache_axi_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR_I = 3'd1;
  localparam logic [2:0] ST_AR_D = 3'd2;
  localparam logic [2:0] ST_R_I  = 3'd3;
  localparam logic [2:0] ST_R_D  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    AR_I = ST_AR_I,
    AR_D = ST_AR_D,
    R_I  = ST_R_I,
    R_D  = ST_R_D
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int BURST_LEN_DEFAULT = 8;

endpackage

// File: rtl/cache_axi_rd_arbiter.sv
// cache_axi_rd_arbiter: shares one AXI read port between the icache and dcache
// refill engines. One burst is in flight at a time; the granted requester's
// address is forwarded, its beats are passed straight through, and the port is
// released on the last beat.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants on a
// simultaneous request; otherwise the dcache always wins a tie.
module cache_axi_rd_arbiter
  import cache_axi_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEFAULT,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic              i_arvalid,
  output logic              i_arready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_rlast,
  input  logic              i_rready,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic              d_arvalid,
  output logic              d_arready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_rlast,
  input  logic              d_rready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid,
  input  logic              m_rlast,
  output logic              m_rready,
  output logic              err_len
);

  localparam int              CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              err_len_q, err_len_d;
  logic              winner;
  logic              r_hs;

`ifdef ARB_ROUND_ROBIN_EN
  // Tie goes to whichever requester was not served last.
  function automatic logic pick_winner(input logic i_req, input logic d_req,
                                       input logic prev_grant);
    logic w;
    w = REQ_I;
    if (i_req && d_req) begin
      w = (prev_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (d_req) begin
      w = REQ_D;
    end
    return w;
  endfunction
`else
  // Tie always goes to the dcache; last_grant is kept for observability only.
  function automatic logic pick_winner(input logic i_req, input logic d_req);
    logic w;
    w = REQ_I;
    if (d_req) begin
      w = REQ_D;
    end else if (i_req) begin
      w = REQ_I;
    end
    return w;
  endfunction

  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  assign m_arlen  = 8'(BURST_LEN - 1);
  assign m_araddr = araddr_q;
  assign err_len  = err_len_q;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign r_hs     = m_rvalid & m_rready;

  // Handshake steering: everything is decoded from the registered state so
  // the data path stays zero-latency and all controls drop to 0 in IDLE.
  always_comb begin
    i_arready = 1'b0;
    d_arready = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rlast   = 1'b0;
    d_rlast   = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    case (state_q)
      AR_I: begin
        m_arvalid = 1'b1;
        i_arready = m_arready;
      end
      AR_D: begin
        m_arvalid = 1'b1;
        d_arready = m_arready;
      end
      R_I: begin
        i_rvalid = m_rvalid;
        i_rlast  = m_rlast;
        m_rready = i_rready;
      end
      R_D: begin
        d_rvalid = m_rvalid;
        d_rlast  = m_rlast;
        m_rready = d_rready;
      end
      default: ;
    endcase
  end

  // Next-state: arbitration in IDLE, address hand-off, then beat counting
  // with a length check; only m_rlast ever ends the data phase.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    araddr_d     = araddr_q;
    err_len_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    winner = pick_winner(i_arvalid, d_arvalid, last_grant_q);
`else
    winner = pick_winner(i_arvalid, d_arvalid);
`endif
    case (state_q)
      IDLE: begin
        if (i_arvalid || d_arvalid) begin
          if (winner == REQ_D) begin
            state_d  = AR_D;
            araddr_d = d_araddr;
          end else begin
            state_d  = AR_I;
            araddr_d = i_araddr;
          end
        end
      end
      AR_I: begin
        if (m_arready) begin
          state_d = R_I;
          cnt_d   = '0;
        end
      end
      AR_D: begin
        if (m_arready) begin
          state_d = R_D;
          cnt_d   = '0;
        end
      end
      R_I, R_D: begin
        if (r_hs) begin
          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          err_len_d = m_rlast ^ (cnt_q == CNT_LAST);
          if (m_rlast) begin
            state_d      = IDLE;
            last_grant_d = (state_q == R_D) ? REQ_D : REQ_I;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any burst in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_I;
      cnt_q        <= '0;
      araddr_q     <= '0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      araddr_q     <= araddr_d;
      err_len_q    <= err_len_d;
    end
  end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// tb_cache_axi_rd_arbiter: directed bench for the cache AXI read arbiter.
// Covers both tie-break builds selected by ARB_ROUND_ROBIN_EN.
module tb_cache_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_araddr = '0;
  logic        i_arvalid = 1'b0;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        i_rlast;
  logic        i_rready = 1'b0;
  logic [31:0] d_araddr = '0;
  logic        d_arvalid = 1'b0;
  logic        d_arready;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_rlast;
  logic        d_rready = 1'b0;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_rvalid = 1'b0;
  logic        m_rlast = 1'b0;
  logic        m_rready;
  logic        err_len;

  int checkCount = 0;
  int passCount  = 0;

  cache_axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rready(d_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                               input logic dv, input logic [31:0] da);
    i_arvalid = iv;
    i_araddr  = ia;
    d_arvalid = dv;
    d_araddr  = da;
  endtask

  // Requests are already applied and the FSM is in IDLE: grant, optional
  // m_arready stall, then the address handshake.
  task automatic requestGrant(input logic win_d, input logic [31:0] exp_addr, input int stall);
    m_arready = 1'b0;
    #1 checkOutput("idle_arvalid", m_arvalid, 0);
    tick;
    checkOutput("grant_arvalid", m_arvalid, 1);
    checkOutput("grant_addr", m_araddr, exp_addr);
    for (int s = 0; s < stall; s++) begin
      checkOutput("stall_arready", win_d ? d_arready : i_arready, 0);
      tick;
      checkOutput("stall_arvalid", m_arvalid, 1);
      checkOutput("stall_addr", m_araddr, exp_addr);
    end
    m_arready = 1'b1;
    #1;
    checkOutput("win_arready", win_d ? d_arready : i_arready, 1);
    checkOutput("lose_arready", win_d ? i_arready : d_arready, 0);
    tick;
    m_arready = 1'b0;
    if (win_d) d_arvalid = 1'b0;
    else i_arvalid = 1'b0;
    checkOutput("in_r_state", dut.state_q, win_d ? 3'd4 : 3'd3);
  endtask

  // Drives nbeats beats; rlast_at marks the beat carrying m_rlast (-1: none),
  // hold_at inserts two cycles of requester backpressure before that beat.
  // err_len is predicted from a saturating beat count starting at cnt_start.
  task automatic doBurst(input logic to_d, input logic [31:0] base, input int nbeats,
                         input int rlast_at, input int hold_at, input int cnt_start);
    int   cnt;
    logic exp_err;
    cnt = cnt_start;
    for (int b = 0; b < nbeats; b++) begin
      if (b == hold_at) begin
        for (int h = 0; h < 2; h++) begin
          m_rvalid = 1'b1; m_rdata = base + b; m_rlast = (b == rlast_at);
          i_rready = to_d; d_rready = !to_d;
          #1 checkOutput("hold_rready", m_rready, 0);
          tick;
          checkOutput("hold_err", err_len, 0);
        end
      end
      m_rvalid = 1'b1; m_rdata = base + b; m_rlast = (b == rlast_at);
      i_rready = !to_d; d_rready = to_d;
      #1;
      checkOutput("beat_data", to_d ? d_rdata : i_rdata, base + b);
      checkOutput("beat_valid", to_d ? d_rvalid : i_rvalid, 1);
      checkOutput("other_valid", to_d ? i_rvalid : d_rvalid, 0);
      checkOutput("other_last", to_d ? i_rlast : d_rlast, 0);
      checkOutput("beat_last", to_d ? d_rlast : i_rlast, b == rlast_at);
      checkOutput("beat_rready", m_rready, 1);
      exp_err = (b == rlast_at) ^ (cnt == 7);
      if (cnt < 7) cnt++;
      tick;
      checkOutput("err_len", err_len, exp_err);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; i_rready = 1'b0; d_rready = 1'b0;
  endtask

  // Main directed sequence.
  initial begin
    #2;
    checkOutput("rst_m_arvalid", m_arvalid, 0);
    checkOutput("rst_m_rready", m_rready, 0);
    checkOutput("rst_i_arready", i_arready, 0);
    checkOutput("rst_d_arready", d_arready, 0);
    checkOutput("rst_i_rvalid", i_rvalid, 0);
    checkOutput("rst_d_rvalid", d_rvalid, 0);
    checkOutput("rst_i_rlast", i_rlast, 0);
    checkOutput("rst_d_rlast", d_rlast, 0);
    checkOutput("rst_err_len", err_len, 0);
    checkOutput("rst_m_araddr", m_araddr, 0);
    checkOutput("rst_m_arlen", m_arlen, 7);
    checkOutput("rst_state", dut.state_q, 0);
    checkOutput("rst_last_grant", dut.last_grant_q, 0);
    tick;
    rst = 1'b1;
    tick;

    // Icache alone, 3-cycle address stall, 2-cycle rready hold at beat 4.
    applyStimulus(1'b1, 32'h0000_0000, 1'b0, 32'h0);
    requestGrant(1'b0, 32'h0000_0000, 3);
    doBurst(1'b0, 32'hFEDC_BA90, 8, 7, 4, 0);
    checkOutput("t1_idle", dut.state_q, 0);
    checkOutput("t1_arvalid", m_arvalid, 0);
    checkOutput("t1_last_grant", dut.last_grant_q, 0);

`ifdef ARB_ROUND_ROBIN_EN
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h1000);
    requestGrant(1'b1, 32'h1000, 0);
    doBurst(1'b1, 32'hD000_0000, 8, 7, -1, 0);
    checkOutput("rr_bubble", m_arvalid, 0);
    checkOutput("rr_last_grant_d", dut.last_grant_q, 1);
    requestGrant(1'b0, 32'h40, 0);
    doBurst(1'b0, 32'hA000_0000, 8, 7, -1, 0);
    checkOutput("rr_last_grant_i", dut.last_grant_q, 0);
`else
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h1000);
    requestGrant(1'b1, 32'h1000, 0);
    doBurst(1'b1, 32'hD000_0000, 8, 7, -1, 0);
    checkOutput("fp_bubble", m_arvalid, 0);
    d_arvalid = 1'b1; d_araddr = 32'h2000;
    requestGrant(1'b1, 32'h2000, 0);
    doBurst(1'b1, 32'hD100_0000, 8, 7, -1, 0);
    checkOutput("fp_last_grant_d", dut.last_grant_q, 1);
    requestGrant(1'b0, 32'h40, 0);
    doBurst(1'b0, 32'hA000_0000, 8, 7, -1, 0);
    checkOutput("fp_last_grant_i", dut.last_grant_q, 0);
`endif

    // Early rlast on beat 5: one error pulse, back to IDLE.
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0);
    requestGrant(1'b0, 32'h100, 0);
    doBurst(1'b0, 32'h1111_0000, 6, 5, -1, 0);
    checkOutput("short_idle", dut.state_q, 0);
    tick;
    checkOutput("short_err_once", err_len, 0);

    // Missing rlast on beat 7: error pulse, FSM stays in R_I until rlast.
    applyStimulus(1'b1, 32'h200, 1'b0, 32'h0);
    requestGrant(1'b0, 32'h200, 0);
    doBurst(1'b0, 32'h2222_0000, 8, -1, -1, 0);
    checkOutput("long_stay", dut.state_q, 3);
    tick;
    checkOutput("long_err_once", err_len, 0);
    checkOutput("long_still_r", dut.state_q, 3);
    doBurst(1'b0, 32'h2222_0008, 1, 0, -1, 7);
    checkOutput("long_idle", dut.state_q, 0);

    // Reset asserted during beat 3.
    applyStimulus(1'b1, 32'h300, 1'b0, 32'h0);
    requestGrant(1'b0, 32'h300, 0);
    doBurst(1'b0, 32'h3333_0000, 3, -1, -1, 0);
    m_rvalid = 1'b1; m_rdata = 32'h3333_0003; i_rready = 1'b1;
    #1 checkOutput("pre_rst_rvalid", i_rvalid, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("mid_rst_rvalid", i_rvalid, 0);
    checkOutput("mid_rst_rready", m_rready, 0);
    checkOutput("mid_rst_arvalid", m_arvalid, 0);
    checkOutput("mid_rst_err", err_len, 0);
    checkOutput("mid_rst_araddr", m_araddr, 0);
    checkOutput("mid_rst_state", dut.state_q, 0);
    m_rvalid = 1'b0; i_rready = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    applyStimulus(1'b1, 32'h80, 1'b0, 32'h0);
    requestGrant(1'b0, 32'h80, 0);
    doBurst(1'b0, 32'h4444_0000, 8, 7, -1, 0);
    checkOutput("post_rst_idle", dut.state_q, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Guards against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
